// File: rtl/dsi_pkt_check_gen.sv
// DSI transmit-path helper: divided dsi_clk, 8-bit header ECC, and 16-bit
// payload CRC with a streamed-byte-count check against the header word count.
module dsi_pkt_check_gen #(
    parameter int CLK_DIV = 2,
    parameter int WC_W    = 16
) (
    input  logic        pclk,
    input  logic        dsi_rst,
    output logic        dsi_clk,
    input  logic        hdr_valid,
    input  logic [23:0] hdr_data,
    output logic [7:0]  ecc,
    output logic        ecc_done,
    input  logic        crc_start,
    input  logic        pay_valid,
    input  logic [7:0]  pay_byte,
    input  logic        pay_last,
    output logic [15:0] crc,
    output logic        crc_done,
    output logic        len_err
);

    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DW-1:0]   div_q, div_d;
    logic            dsi_clk_q, dsi_clk_d;
    logic [7:0]      ecc_q, ecc_d;
    logic            ecc_done_q;
    logic [WC_W-1:0] wc_q, wc_d;
    logic [15:0]     acc_q, acc_d;
    logic [WC_W-1:0] cnt_q, cnt_d;
    logic [15:0]     crc_q, crc_d;
    logic            crc_done_d, crc_done_q;
    logic            len_err_d, len_err_q;

    logic [15:0]     base_acc, upd_acc;
    logic [WC_W-1:0] base_cnt, upd_cnt;

    // Reflected CCITT polynomial, one full byte per call, LSB first.
    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] eccCalc(input logic [23:0] d);
        logic [7:0] p;
        p    = 8'h00;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

    always_comb begin
        div_d     = div_q + DW'(1);
        dsi_clk_d = dsi_clk_q;
        if (div_q == DW'(HALF - 1)) begin
            div_d     = '0;
            dsi_clk_d = ~dsi_clk_q;
        end
    end

    always_comb begin
        ecc_d = ecc_q;
        wc_d  = wc_q;
        if (hdr_valid) begin
            ecc_d = eccCalc(hdr_data);
            wc_d  = WC_W'(hdr_data[23:8]);
        end
    end

    // A start this cycle restarts from init before any byte or termination is applied.
    always_comb begin
        base_acc   = crc_start ? 16'hFFFF : acc_q;
        base_cnt   = crc_start ? '0 : cnt_q;
        upd_acc    = base_acc;
        upd_cnt    = base_cnt;
        if (pay_valid) begin
            upd_acc = crcByte(base_acc, pay_byte);
            if (base_cnt != {WC_W{1'b1}}) upd_cnt = base_cnt + WC_W'(1);
        end
        acc_d      = upd_acc;
        cnt_d      = upd_cnt;
        crc_d      = crc_q;
        crc_done_d = 1'b0;
        len_err_d  = 1'b0;
        if (pay_last) begin
            crc_d      = upd_acc;
            crc_done_d = 1'b1;
            len_err_d  = (upd_cnt != wc_q);
            acc_d      = 16'hFFFF;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge pclk or posedge dsi_rst) begin
        if (dsi_rst) begin
            div_q      <= '0;
            dsi_clk_q  <= 1'b0;
            ecc_q      <= 8'h00;
            ecc_done_q <= 1'b0;
            wc_q       <= '0;
            acc_q      <= 16'hFFFF;
            cnt_q      <= '0;
            crc_q      <= 16'hFFFF;
            crc_done_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            dsi_clk_q  <= dsi_clk_d;
            ecc_q      <= ecc_d;
            ecc_done_q <= hdr_valid;
            wc_q       <= wc_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            crc_done_q <= crc_done_d;
            len_err_q  <= len_err_d;
        end
    end

    assign dsi_clk  = dsi_clk_q;
    assign ecc      = ecc_q;
    assign ecc_done = ecc_done_q;
    assign crc      = crc_q;
    assign crc_done = crc_done_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_dsi_pkt_check_gen.sv
// Directed self-checking bench for dsi_pkt_check_gen: divider, ECC vectors,
// and payload CRC/length checks with hand-computed expected values.
module tb_dsi_pkt_check_gen;

    logic        pclk;
    logic        dsi_rst;
    logic        dsi_clk;
    logic        hdr_valid;
    logic [23:0] hdr_data;
    logic [7:0]  ecc;
    logic        ecc_done;
    logic        crc_start;
    logic        pay_valid;
    logic [7:0]  pay_byte;
    logic        pay_last;
    logic [15:0] crc;
    logic        crc_done;
    logic        len_err;

    int checks = 0;
    int errors = 0;

    dsi_pkt_check_gen #(.CLK_DIV(2), .WC_W(16)) dut (
        .pclk      (pclk),
        .dsi_rst   (dsi_rst),
        .dsi_clk   (dsi_clk),
        .hdr_valid (hdr_valid),
        .hdr_data  (hdr_data),
        .ecc       (ecc),
        .ecc_done  (ecc_done),
        .crc_start (crc_start),
        .pay_valid (pay_valid),
        .pay_byte  (pay_byte),
        .pay_last  (pay_last),
        .crc       (crc),
        .crc_done  (crc_done),
        .len_err   (len_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendHeader(input logic [23:0] d);
        hdr_valid = 1'b1;
        hdr_data  = d;
        @(negedge pclk);
        hdr_valid = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic last, input logic start);
        pay_valid = 1'b1;
        pay_byte  = b;
        pay_last  = last;
        crc_start = start;
        @(negedge pclk);
        pay_valid = 1'b0;
        pay_last  = 1'b0;
        crc_start = 1'b0;
    endtask

    task automatic startOnly();
        crc_start = 1'b1;
        @(negedge pclk);
        crc_start = 1'b0;
    endtask

    logic [7:0] msg [9];

    initial begin
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        dsi_rst   = 1'b1;
        hdr_valid = 1'b0;
        hdr_data  = '0;
        crc_start = 1'b0;
        pay_valid = 1'b0;
        pay_byte  = '0;
        pay_last  = 1'b0;

        repeat (2) @(negedge pclk);
        checkOutput("rst_dsi_clk", 32'(dsi_clk), 32'h0);
        checkOutput("rst_ecc", 32'(ecc), 32'h00);
        checkOutput("rst_ecc_done", 32'(ecc_done), 32'h0);
        checkOutput("rst_crc", 32'(crc), 32'hFFFF);
        checkOutput("rst_crc_done", 32'(crc_done), 32'h0);
        checkOutput("rst_len_err", 32'(len_err), 32'h0);

        dsi_rst = 1'b0;
        @(negedge pclk);
        checkOutput("div_1", 32'(dsi_clk), 32'h1);
        @(negedge pclk);
        checkOutput("div_2", 32'(dsi_clk), 32'h0);
        @(negedge pclk);
        checkOutput("div_3", 32'(dsi_clk), 32'h1);

        sendHeader(24'h000000);
        checkOutput("ecc_000000_done", 32'(ecc_done), 32'h1);
        checkOutput("ecc_000000", 32'(ecc), 32'h00);
        sendHeader(24'h000001);
        checkOutput("ecc_000001_done", 32'(ecc_done), 32'h1);
        checkOutput("ecc_000001", 32'(ecc), 32'h07);
        sendHeader(24'h800000);
        checkOutput("ecc_800000_done", 32'(ecc_done), 32'h1);
        checkOutput("ecc_800000", 32'(ecc), 32'h3B);
        sendHeader(24'hFFFFFF);
        checkOutput("ecc_FFFFFF_done", 32'(ecc_done), 32'h1);
        checkOutput("ecc_FFFFFF", 32'(ecc), 32'h3C);
        @(negedge pclk);
        checkOutput("ecc_done_drop", 32'(ecc_done), 32'h0);
        checkOutput("ecc_hold", 32'(ecc), 32'h3C);

        // Check string with WC=9
        sendHeader(24'h000929);
        startOnly();
        for (int i = 0; i < 8; i++) sendByte(msg[i], 1'b0, 1'b0);
        checkOutput("crc_no_early_done", 32'(crc_done), 32'h0);
        sendByte(msg[8], 1'b1, 1'b0);
        checkOutput("crc_chk_done", 32'(crc_done), 32'h1);
        checkOutput("crc_chk", 32'(crc), 32'h6F91);
        checkOutput("crc_chk_len_err", 32'(len_err), 32'h0);
        @(negedge pclk);
        checkOutput("crc_done_drop", 32'(crc_done), 32'h0);
        checkOutput("crc_hold", 32'(crc), 32'h6F91);

        // Zero-length payload
        sendHeader(24'h000029);
        startOnly();
        pay_last = 1'b1;
        @(negedge pclk);
        pay_last = 1'b0;
        checkOutput("zero_done", 32'(crc_done), 32'h1);
        checkOutput("zero_crc", 32'(crc), 32'hFFFF);
        checkOutput("zero_len_err", 32'(len_err), 32'h0);

        // Length mismatch: WC=4, three bytes, start merged with first byte
        sendHeader(24'h000429);
        sendByte(msg[0], 1'b0, 1'b1);
        sendByte(msg[1], 1'b0, 1'b0);
        sendByte(msg[2], 1'b1, 1'b0);
        checkOutput("mis_done", 32'(crc_done), 32'h1);
        checkOutput("mis_len_err", 32'(len_err), 32'h1);
        @(negedge pclk);
        checkOutput("mis_len_err_drop", 32'(len_err), 32'h0);

        // Check string with idle gaps
        sendHeader(24'h000929);
        startOnly();
        for (int i = 0; i < 9; i++) begin
            if (i == 3 || i == 6) repeat (2) @(negedge pclk);
            sendByte(msg[i], (i == 8), 1'b0);
        end
        checkOutput("gap_done", 32'(crc_done), 32'h1);
        checkOutput("gap_crc", 32'(crc), 32'h6F91);
        checkOutput("gap_len_err", 32'(len_err), 32'h0);

        // Abort at byte 5 by restarting; the restart carries the first byte
        startOnly();
        sendByte(8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sendByte(msg[i], 1'b0, 1'b0);
        sendByte(msg[0], 1'b0, 1'b1);
        checkOutput("abort_no_done", 32'(crc_done), 32'h0);
        checkOutput("abort_crc_kept", 32'(crc), 32'h6F91);
        for (int i = 1; i < 9; i++) sendByte(msg[i], (i == 8), 1'b0);
        checkOutput("abort_done", 32'(crc_done), 32'h1);
        checkOutput("abort_crc", 32'(crc), 32'h6F91);
        checkOutput("abort_len_err", 32'(len_err), 32'h0);

        // No crc_start: accumulator re-initialised after the previous packet
        sendHeader(24'h000000);
        for (int i = 0; i < 9; i++) sendByte(msg[i], (i == 8), 1'b0);
        checkOutput("nostart_crc_done", 32'(crc_done), 32'h1);
        checkOutput("nostart_crc", 32'(crc), 32'h6F91);
        checkOutput("nostart_len_err", 32'(len_err), 32'h1);

        // Asynchronous reset mid-run while dsi_clk is high
        @(negedge pclk);
        if (dsi_clk !== 1'b1) @(negedge pclk);
        checkOutput("pre_rst_dsi_clk", 32'(dsi_clk), 32'h1);
        dsi_rst = 1'b1;
        #1;
        checkOutput("async_rst_dsi_clk", 32'(dsi_clk), 32'h0);
        checkOutput("async_rst_crc", 32'(crc), 32'hFFFF);
        checkOutput("async_rst_ecc", 32'(ecc), 32'h00);
        @(negedge pclk);
        dsi_rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsi_pkt_check_gen.md
Name: dsi_pkt_check_gen

Overview:
- Packet-protection and clock helper for the DSI transmit path, between the line FIFO and the packetizer.
- Generates the divided `dsi_clk` from `pclk`.
- Computes the 8-bit MIPI DSI header ECC over the 24-bit packet header.
- Computes the 16-bit MIPI DSI payload CRC over a byte stream and checks the streamed byte count against the header word count.

Parameters:
- CLK_DIV, 2: pclk-to-dsi_clk division ratio; even, >= 2.
- WC_W, 16: word-count width in bits.

Ports:
- pclk  input  1  sole clock; all logic on its rising edge.
- dsi_rst  input  1  reset, asynchronous, active-high.
- dsi_clk  output  1  divided clock, registered, 50% duty.
- hdr_valid  input  1  one-cycle strobe; hdr_data is valid.
- hdr_data  input  24  packet header; [7:0]=DI, [23:8]=WC (little-endian word count).
- ecc  output  8  header ECC, registered.
- ecc_done  output  1  one-cycle pulse; ecc updated.
- crc_start  input  1  begin a new payload; CRC accumulator := 16'hFFFF, byte counter := 0.
- pay_valid  input  1  pay_byte valid this cycle.
- pay_byte  input  8  payload byte.
- pay_last  input  1  with pay_valid: final byte; alone (no pay_valid): terminate with no byte.
- crc  output  16  final payload CRC, registered.
- crc_done  output  1  one-cycle pulse; crc updated.
- len_err  output  1  one-cycle pulse with crc_done when byte count != latched WC.

Behaviour:

Reset (dsi_rst high, async):
- dsi_clk=0, divider counter=0.
- ecc=0, ecc_done=0.
- crc=16'hFFFF, crc_done=0, len_err=0.
- Accumulator=16'hFFFF, byte counter=0, latched WC=0.
- Reset mid-packet discards all progress.

Clock divider:
- Counter 0..CLK_DIV/2-1; dsi_clk toggles when the counter wraps.
- CLK_DIV=2: dsi_clk toggles every pclk edge; first rise on the first pclk edge after reset release.

ECC:
- On hdr_valid, register ecc and pulse ecc_done the next cycle (latency 1).
- Also on hdr_valid, latch WC=hdr_data[23:8].
- D = hdr_data. Each parity bit is the XOR of the listed data bits:
  - P0 = D0,1,2,4,5,7,10,11,13,16,20,21,22,23
  - P1 = D0,1,3,4,6,8,10,12,14,17,20,21,22,23
  - P2 = D0,2,3,5,6,9,11,12,15,18,20,21,22
  - P3 = D1,2,3,7,8,9,13,14,15,19,20,21,23
  - P4 = D4,5,6,7,8,9,16,17,18,19,20,22,23
  - P5 = D10..19,21,22,23
  - ecc = {2'b00, P5..P0}
- ecc holds until the next hdr_valid.
- Back-to-back hdr_valid: each produces its own result one cycle later.

CRC:
- Algorithm: poly x^16+x^12+x^5+1, reflected (0x8408), init 0xFFFF, bytes processed LSB first, no final XOR, no output reflection.
- Rate: one byte per cycle while pay_valid; the full 8-bit update is applied in one cycle (combinational unrolled loop).
- Each accepted byte increments the byte counter, saturating at 2^WC_W-1.
- Termination: pay_last (with or without pay_valid) completes the packet.
  - The next cycle, crc = final accumulator (including the last byte if valid) and crc_done pulses.
  - len_err pulses in the same cycle if final count != latched WC.
  - The accumulator then reinitialises to 0xFFFF and the counter clears.
- Zero-length payload (pay_last alone, WC=0): crc=16'hFFFF, len_err=0.
- crc_start together with pay_valid: the byte is processed from the 0xFFFF init.
- crc_start together with pay_last: treated as start then last.
- crc_start mid-packet: aborts the packet silently; no crc_done.
- pay_valid without a prior crc_start: accumulates from the current state (0xFFFF after reset or after a completed packet).
- The ECC and CRC paths are independent; simultaneous activity on both is legal.

Test Plan:
- Clock divider: release reset, CLK_DIV=2 -> dsi_clk toggles every pclk edge, 0 during reset; assert reset mid-run -> dsi_clk=0 immediately.
- ECC vectors:
  - hdr_data 24'h000000 -> ecc 8'h00.
  - 24'h000001 -> 8'h07.
  - 24'h800000 -> 8'h3B.
  - 24'hFFFFFF -> 8'h3C.
  - ecc_done pulses exactly 1 cycle after each hdr_valid, including back-to-back.
- CRC check string: header WC=9, crc_start, stream ASCII "123456789" (0x31..0x39) on consecutive cycles with pay_last on 0x39 -> crc=16'h6F91, crc_done 1 cycle after last byte, len_err=0.
- Zero-length: header WC=0, crc_start then pay_last alone -> crc=16'hFFFF, crc_done=1, len_err=0.
- Length mismatch: header WC=4, stream 3 bytes with pay_last -> crc_done and len_err pulse together.
- Gaps and abort: "123456789" with pay_valid gaps -> still 16'h6F91; crc_start at byte 5 of a stream -> no crc_done; the following 9-byte stream -> 16'h6F91.
